// File: rtl/tlul_host_arb_2_1.sv
// 2:1 TL-UL host arbiter: round-robin (or h0-priority) A-channel grant with lock,
// in-order D-channel steering through an outstanding host-ID FIFO.
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_arb_2_1
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutst = 4,
  parameter bit          H0Prio   = 1'b0
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_h2d_h0,
  output tl_d2h_t tl_d2h_h0,
  input  tl_h2d_t tl_h2d_h1,
  output tl_d2h_t tl_d2h_h1,
  output tl_h2d_t tl_h2d_o,
  input  tl_d2h_t tl_d2h_i,
  output logic    busy_o
);

  localparam int unsigned PW = $clog2(MaxOutst);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] Depth = CW'(MaxOutst);

  typedef enum logic {StIdle, StLock} state_e;

  state_e          state_q, state_d;
  logic            lock_host_q, lock_host_d;
  logic            rr_q;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic            id_mem [MaxOutst];

  logic    gnt, empty, full, head, pop, stall, a_valid_out, accept, d_ready_out;
  tl_h2d_t sel_h2d;

  assign empty = (count_q == '0);
  assign full  = (count_q == Depth);
  assign head  = id_mem[rptr_q];

  always_comb begin
    gnt = 1'b0;
    if (state_q == StLock)                         gnt = lock_host_q;
    else if (tl_h2d_h0.a_valid && tl_h2d_h1.a_valid) gnt = H0Prio ? 1'b0 : rr_q;
    else                                           gnt = tl_h2d_h1.a_valid;
  end

  // A pop frees a slot in the same cycle, so a full FIFO still admits a beat then.
  assign d_ready_out = empty ? 1'b1 : (head ? tl_h2d_h1.d_ready : tl_h2d_h0.d_ready);
  assign pop         = tl_d2h_i.d_valid && d_ready_out && !empty;
  assign stall       = rst_i || (full && !pop);
  assign sel_h2d     = gnt ? tl_h2d_h1 : tl_h2d_h0;
  assign a_valid_out = sel_h2d.a_valid && !stall;
  assign accept      = a_valid_out && tl_d2h_i.a_ready;
  assign busy_o      = !rst_i && (!empty || tl_h2d_h0.a_valid || tl_h2d_h1.a_valid);

  always_comb begin
    tl_h2d_o         = sel_h2d;
    tl_h2d_o.a_valid = a_valid_out;
    tl_h2d_o.d_ready = d_ready_out;

    tl_d2h_h0         = tl_d2h_i;
    tl_d2h_h0.a_ready = !stall && !gnt && tl_d2h_i.a_ready;
    tl_d2h_h0.d_valid = !rst_i && !empty && !head && tl_d2h_i.d_valid;

    tl_d2h_h1         = tl_d2h_i;
    tl_d2h_h1.a_ready = !stall && gnt && tl_d2h_i.a_ready;
    tl_d2h_h1.d_valid = !rst_i && !empty && head && tl_d2h_i.d_valid;
  end

  always_comb begin
    state_d     = state_q;
    lock_host_d = lock_host_q;
    case (state_q)
      StIdle: if (a_valid_out && !tl_d2h_i.a_ready) begin
        state_d     = StLock;
        lock_host_d = gnt;
      end
      StLock: if (accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      lock_host_q <= 1'b0;
      rr_q        <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      lock_host_q <= lock_host_d;
      if (accept) begin
        rr_q   <= ~gnt;
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      case ({accept, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) id_mem[wptr_q] <= gnt;
  end

  // A D beat with nothing outstanding is a target protocol error; it is drained, never popped.
  stray_d_beat: assert property (@(posedge clk_i) disable iff (rst_i)
                                 !(tl_d2h_i.d_valid && empty));

endmodule

// File: tb/tb_tlul_host_arb_2_1.sv
// Scoreboard bench for tlul_host_arb_2_1: round-robin instance plus an h0-priority instance.
module tb_tlul_host_arb_2_1;
  import tlul_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl_h2d_t h0, h1, o;
  tl_d2h_t d0, d1, ti;
  logic    busy;
  tl_h2d_t ph0, ph1, po;
  tl_d2h_t pd0, pd1, pti;
  logic    pbusy;

  tlul_host_arb_2_1 #(.MaxOutst(4), .H0Prio(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .tl_h2d_h0(h0), .tl_d2h_h0(d0), .tl_h2d_h1(h1), .tl_d2h_h1(d1),
    .tl_h2d_o(o), .tl_d2h_i(ti), .busy_o(busy));

  tlul_host_arb_2_1 #(.MaxOutst(4), .H0Prio(1'b1)) dut_p (
    .clk_i(clk), .rst_i(rst),
    .tl_h2d_h0(ph0), .tl_d2h_h0(pd0), .tl_h2d_h1(ph1), .tl_d2h_h1(pd1),
    .tl_h2d_o(po), .tl_d2h_i(pti), .busy_o(pbusy));

  int n_vec = 0, n_err = 0, n_acc = 0;
  logic [7:0] h0q[$], h1q[$], t_q[$], exp_a[$], exp_d0[$], exp_d1[$];
  bit exp_p[$];
  bit h0en = 1, h1en = 1, h0dr = 1, t_ready = 1, t_den = 1;
  bit af0, af1, taf, paf0, paf1, pacc;
  bit tdf;
  logic [7:0] cap_src;
  int p_left0 = 0, p_left1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic tl_h2d_t mk_req(input logic [7:0] src, input bit en, input bit dr);
    mk_req           = '0;
    mk_req.a_valid   = en;
    mk_req.a_opcode  = 3'd4;
    mk_req.a_size    = 2'd2;
    mk_req.a_source  = src;
    mk_req.a_address = 32'h4000_0000 | {20'h0, src, 4'h0};
    mk_req.a_mask    = 4'hF;
    mk_req.d_ready   = dr;
  endfunction

  // Host and target drivers: act on handshakes the monitor saw before this edge.
  initial begin
    logic [7:0] s0, s1;
    h0 = '0; h1 = '0; ti = '0; ph0 = '0; ph1 = '0; pti = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) t_q.delete();
      else begin
        if (af0 && h0q.size() > 0) void'(h0q.pop_front());
        if (af1 && h1q.size() > 0) void'(h1q.pop_front());
        if (tdf && t_q.size() > 0) void'(t_q.pop_front());
        if (taf) t_q.push_back(cap_src);
        if (paf0) p_left0--;
        if (paf1) p_left1--;
      end
      s0 = (h0q.size() > 0) ? h0q[0] : 8'h00;
      s1 = (h1q.size() > 0) ? h1q[0] : 8'h00;
      h0 = mk_req(s0, h0en && h0q.size() > 0, h0dr);
      h1 = mk_req(s1, h1en && h1q.size() > 0, 1'b1);
      ti = '0;
      ti.a_ready = t_ready;
      if (t_den && t_q.size() > 0) begin
        ti.d_valid  = 1'b1;
        ti.d_opcode = 3'd1;
        ti.d_size   = 2'd2;
        ti.d_source = t_q[0];
        ti.d_data   = 32'hA5A5_0000 | {24'h0, t_q[0]};
      end
      ph0 = mk_req(8'h00, p_left0 > 0, 1'b1);
      ph1 = mk_req(8'h80, p_left1 > 0, 1'b1);
      pti = '0;
      pti.a_ready = 1'b1;
      pti.d_valid = !rst && pacc;
    end
  end

  // Monitor: samples at negedge, pops the scoreboard on every handshake.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      af0 = 0; af1 = 0; taf = 0; tdf = 0; paf0 = 0; paf1 = 0; pacc = 0;
    end else begin
      af0  = h0.a_valid && d0.a_ready;
      af1  = h1.a_valid && d1.a_ready;
      taf  = o.a_valid && ti.a_ready;
      tdf  = ti.d_valid && o.d_ready;
      paf0 = ph0.a_valid && pd0.a_ready;
      paf1 = ph1.a_valid && pd1.a_ready;
      pacc = po.a_valid && pti.a_ready;
      if (taf) begin
        cap_src = o.a_source;
        n_acc++;
        if (exp_a.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL a_unexpected: actual source %0h required none", o.a_source);
        end else begin
          e = exp_a.pop_front();
          chk("a_source", o.a_source, e);
          chk("a_address", o.a_address, 32'h4000_0000 | {20'h0, e, 4'h0});
          chk("a_grant_host", {af1, af0}, e[7] ? 2'b10 : 2'b01);
        end
      end
      if (d0.d_valid && h0.d_ready) begin
        if (exp_d0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL d0_unexpected: actual source %0h required none", d0.d_source);
        end else begin
          e = exp_d0.pop_front();
          chk("d0_source", d0.d_source, e);
          chk("d0_data", d0.d_data, 32'hA5A5_0000 | {24'h0, e});
          chk("d0_other_quiet", d1.d_valid, 0);
        end
      end
      if (d1.d_valid && h1.d_ready) begin
        if (exp_d1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL d1_unexpected: actual source %0h required none", d1.d_source);
        end else begin
          e = exp_d1.pop_front();
          chk("d1_source", d1.d_source, e);
          chk("d1_data", d1.d_data, 32'hA5A5_0000 | {24'h0, e});
          chk("d1_other_quiet", d0.d_valid, 0);
        end
      end
      if (pacc) begin
        if (exp_p.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL prio_unexpected: actual source %0h required none", po.a_source);
        end else chk("prio_grant_host", po.a_source[7], exp_p.pop_front());
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int i = 0;
    while ((exp_a.size() + exp_d0.size() + exp_d1.size()) != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_drained"}, exp_a.size() + exp_d0.size() + exp_d1.size(), 0);
    @(negedge clk);
    chk({name, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    int acc0, i;
    h0q = '{8'h00, 8'h01};
    h1q = '{8'h80, 8'h81};
    exp_a  = '{8'h00, 8'h80, 8'h01, 8'h81};
    exp_d0 = '{8'h00, 8'h01};
    exp_d1 = '{8'h80, 8'h81};

    // Reset with both hosts requesting
    @(negedge clk);
    chk("rst_a_valid", o.a_valid, 0);
    chk("rst_h0_a_ready", d0.a_ready, 0);
    chk("rst_h1_a_ready", d1.a_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_d_valid", {d1.d_valid, d0.d_valid}, 0);
    chk("rst_p_a_valid", po.a_valid, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Contention round-robin h0,h1,h0,h1
    drain("rr", 40);

    // One h0 beat so the pointer favours h1, then lock test
    h0q.push_back(8'h02); exp_a.push_back(8'h02); exp_d0.push_back(8'h02);
    drain("pre_lock", 20);
    t_ready = 0; h1en = 0;
    h0q.push_back(8'h03); h1q.push_back(8'h82);
    exp_a.push_back(8'h03); exp_a.push_back(8'h82);
    exp_d0.push_back(8'h03); exp_d1.push_back(8'h82);
    @(negedge clk);
    chk("lock_first_src", o.a_source, 8'h03);
    h1en = 1;
    repeat (2) begin
      @(negedge clk);
      chk("lock_hold_valid", o.a_valid, 1);
      chk("lock_hold_src", o.a_source, 8'h03);
    end
    t_ready = 1;
    @(negedge clk);
    chk("lock_release_h0_ready", d0.a_ready, 1);
    chk("lock_release_h1_ready", d1.a_ready, 0);
    drain("lock", 30);

    // FIFO full: 6 Gets, no responses
    t_den = 0;
    for (int k = 4; k < 10; k++) begin
      h0q.push_back(8'(k)); exp_a.push_back(8'(k)); exp_d0.push_back(8'(k));
    end
    acc0 = n_acc;
    repeat (10) @(negedge clk);
    chk("full_accepted", n_acc - acc0, 4);
    chk("full_a_ready", d0.a_ready, 0);
    chk("full_a_valid_out", o.a_valid, 0);
    chk("full_busy", busy, 1);
    t_den = 1;
    @(negedge clk);
    chk("full_pop_d_valid", d0.d_valid, 1);
    chk("full_admit_a_ready", d0.a_ready, 1);
    chk("full_admit_a_valid", o.a_valid, 1);
    drain("full", 40);

    // D backpressure from head host h0
    h0dr = 0;
    h0q.push_back(8'h0A); exp_a.push_back(8'h0A); exp_d0.push_back(8'h0A);
    i = 0;
    while (!d0.d_valid && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("bp_d_valid_seen", d0.d_valid, 1);
    repeat (2) begin
      @(negedge clk);
      chk("bp_target_d_ready", o.d_ready, 0);
      chk("bp_other_d_valid", d1.d_valid, 0);
      chk("bp_head_d_valid", d0.d_valid, 1);
      chk("bp_busy_held", busy, 1);
    end
    h0dr = 1;
    drain("bp", 20);

    // Fixed priority: h0 wins every beat until it stops requesting
    exp_p = '{0, 0, 0, 0, 0, 1, 1, 1};
    p_left0 = 5; p_left1 = 3;
    i = 0;
    while (exp_p.size() != 0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("prio_all_granted", exp_p.size(), 0);
    repeat (3) @(negedge clk);
    chk("prio_busy_idle", pbusy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, run incomplete");
    $fatal(1);
  end

endmodule
